// File: rtl/unit_clause_scan_ctrl.sv
// Clause-store scanner: reads one clause per request, classifies it as satisfied/unit/conflict,
// and reports the first unit literal or the first conflict to the DPLL controller.
module unit_clause_scan_ctrl #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned NUM_CLAUSES = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  output logic                 o_rd_en,
  output logic [IDX_W-1:0]     o_rd_addr,
  input  logic                 i_rd_valid,
  input  logic [2:0]           i_clause_in,
  input  logic                 i_clause_active_in,
  input  logic [3*WIDTH-1:0]   i_cnf_clause_packed,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_unit_found,
  output logic [WIDTH-2:0]     o_unit_literal,
  output logic                 o_unit_bool_val,
  output logic [IDX_W-1:0]     o_unit_clause_idx,
  output logic                 o_conflict,
  output logic [IDX_W-1:0]     o_conflict_idx,
  output logic [IDX_W:0]       o_active_count,
  output logic                 o_all_sat
);

  localparam int unsigned MAG_W = WIDTH - 1;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]       r_state,        w_nxt_state;
  logic [IDX_W-1:0] r_idx,          w_nxt_idx;
  logic             r_rd_en;
  logic             r_done;
  logic             r_busy,         w_nxt_busy;
  logic             r_unit_found,   w_nxt_unit_found;
  logic [MAG_W-1:0] r_unit_literal, w_nxt_unit_literal;
  logic             r_unit_bool,    w_nxt_unit_bool;
  logic [IDX_W-1:0] r_unit_idx,     w_nxt_unit_idx;
  logic             r_conflict,     w_nxt_conflict;
  logic [IDX_W-1:0] r_conflict_idx, w_nxt_conflict_idx;
  logic [CNT_W-1:0] r_active_count, w_nxt_active_count;
  logic             r_all_sat,      w_nxt_all_sat;
  logic             w_new_conflict;

  logic [2:0][WIDTH-1:0] w_lit;
  logic [2:0][MAG_W-1:0] w_mag;
  logic [2:0]            w_open;
  logic [1:0]            w_open_cnt;
  logic [MAG_W-1:0]      w_u_var;
  logic                  w_u_bool;

  // Slot decode: magnitude of -2^(WIDTH-1) truncates to zero, so it counts as an empty slot.
  always_comb begin
    w_open_cnt = 2'd0;
    w_u_var    = '0;
    w_u_bool   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_lit[i]  = i_cnf_clause_packed[(i+1)*WIDTH-1 -: WIDTH];
      w_mag[i]  = w_lit[i][WIDTH-1] ? MAG_W'(~w_lit[i] + WIDTH'(1)) : w_lit[i][MAG_W-1:0];
      w_open[i] = i_clause_in[i] && (w_mag[i] != '0);
      w_open_cnt = w_open_cnt + 2'(w_open[i]);
      if (w_open[i]) begin
        w_u_var  = w_mag[i];
        w_u_bool = ~w_lit[i][WIDTH-1];
      end
    end
  end

  always_comb begin
    w_nxt_state        = r_state;
    w_nxt_idx          = r_idx;
    w_nxt_busy         = r_busy;
    w_nxt_unit_found   = r_unit_found;
    w_nxt_unit_literal = r_unit_literal;
    w_nxt_unit_bool    = r_unit_bool;
    w_nxt_unit_idx     = r_unit_idx;
    w_nxt_conflict     = r_conflict;
    w_nxt_conflict_idx = r_conflict_idx;
    w_nxt_active_count = r_active_count;
    w_nxt_all_sat      = r_all_sat;
    w_new_conflict     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nxt_unit_found   = 1'b0;
          w_nxt_unit_literal = '0;
          w_nxt_unit_bool    = 1'b0;
          w_nxt_unit_idx     = '0;
          w_nxt_conflict     = 1'b0;
          w_nxt_conflict_idx = '0;
          w_nxt_active_count = '0;
          w_nxt_all_sat      = 1'b0;
          w_nxt_idx          = '0;
          w_nxt_busy         = 1'b1;
          w_nxt_state        = S_ISSUE;
        end
      end
      S_ISSUE: w_nxt_state = S_WAIT;
      S_WAIT: begin
        if (i_rd_valid) begin
          if (i_clause_active_in) begin
            w_nxt_active_count = r_active_count + CNT_W'(1);
            if (w_open_cnt == 2'd0) begin
              w_new_conflict = 1'b1;
            end else if (w_open_cnt == 2'd1) begin
              if (!r_unit_found) begin
                w_nxt_unit_found   = 1'b1;
                w_nxt_unit_literal = w_u_var;
                w_nxt_unit_bool    = w_u_bool;
                w_nxt_unit_idx     = r_idx;
              end else if ((w_u_var == r_unit_literal) && (w_u_bool != r_unit_bool)) begin
                w_new_conflict = 1'b1;
              end
            end
          end
          if (w_new_conflict) begin
            w_nxt_conflict     = 1'b1;
            w_nxt_conflict_idx = r_idx;
          end
          // A pass only ever reaches here conflict-free, so only this clause can raise it.
          if (w_new_conflict || (r_idx == LAST_IDX)) begin
            w_nxt_busy    = 1'b0;
            w_nxt_all_sat = (w_nxt_active_count == '0) && !w_new_conflict;
            w_nxt_state   = S_FIN;
          end else begin
            w_nxt_idx   = r_idx + IDX_W'(1);
            w_nxt_state = S_ISSUE;
          end
        end
      end
      S_FIN:   w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_rd_en        <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_unit_found   <= 1'b0;
      r_unit_literal <= '0;
      r_unit_bool    <= 1'b0;
      r_unit_idx     <= '0;
      r_conflict     <= 1'b0;
      r_conflict_idx <= '0;
      r_active_count <= '0;
      r_all_sat      <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_idx          <= w_nxt_idx;
      r_rd_en        <= (w_nxt_state == S_ISSUE);
      r_done         <= (w_nxt_state == S_FIN);
      r_busy         <= w_nxt_busy;
      r_unit_found   <= w_nxt_unit_found;
      r_unit_literal <= w_nxt_unit_literal;
      r_unit_bool    <= w_nxt_unit_bool;
      r_unit_idx     <= w_nxt_unit_idx;
      r_conflict     <= w_nxt_conflict;
      r_conflict_idx <= w_nxt_conflict_idx;
      r_active_count <= w_nxt_active_count;
      r_all_sat      <= w_nxt_all_sat;
    end
  end

  assign o_rd_en           = r_rd_en;
  assign o_rd_addr         = r_idx;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_unit_found      = r_unit_found;
  assign o_unit_literal    = r_unit_literal;
  assign o_unit_bool_val   = r_unit_bool;
  assign o_unit_clause_idx = r_unit_idx;
  assign o_conflict        = r_conflict;
  assign o_conflict_idx    = r_conflict_idx;
  assign o_active_count    = r_active_count;
  assign o_all_sat         = r_all_sat;

endmodule

// File: tb/tb_unit_clause_scan_ctrl.sv
// Directed bench for unit_clause_scan_ctrl with a 4-clause store of configurable read latency.
module tb_unit_clause_scan_ctrl;
  localparam int W  = 9;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, rd_en, rd_valid, clause_active_in;
  logic [IW-1:0]     rd_addr;
  logic [2:0]        clause_in;
  logic [3*W-1:0]    cnf_clause;
  logic              busy, done, unit_found, unit_bool_val, conflict, all_sat;
  logic [W-2:0]      unit_literal;
  logic [IW-1:0]     unit_clause_idx, conflict_idx;
  logic [IW:0]       active_count;

  logic [2:0]        m_mask [N];
  logic              m_act  [N];
  logic [3*W-1:0]    m_lits [N];
  int                lat = 1;
  logic              pend = 1'b0;
  int                cnt = 0;
  logic [IW-1:0]     paddr = '0;

  int n_cmp = 0;
  int n_err = 0;

  unit_clause_scan_ctrl #(.WIDTH(W), .NUM_CLAUSES(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
    .i_rd_valid(rd_valid), .i_clause_in(clause_in), .i_clause_active_in(clause_active_in),
    .i_cnf_clause_packed(cnf_clause), .o_busy(busy), .o_done(done),
    .o_unit_found(unit_found), .o_unit_literal(unit_literal), .o_unit_bool_val(unit_bool_val),
    .o_unit_clause_idx(unit_clause_idx), .o_conflict(conflict), .o_conflict_idx(conflict_idx),
    .o_active_count(active_count), .o_all_sat(all_sat)
  );

  // Clause store model: answers each read after `lat` clock edges, data held until next read.
  initial rd_valid = 1'b0;
  always @(posedge clk) begin
    rd_valid <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        rd_valid <= 1'b1;
        pend     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (rd_en) begin
      paddr <= rd_addr;
      if (lat == 1) rd_valid <= 1'b1;
      else begin
        pend <= 1'b1;
        cnt  <= lat - 1;
      end
    end
  end

  assign clause_in        = m_mask[paddr];
  assign clause_active_in = m_act[paddr];
  assign cnf_clause       = m_lits[paddr];

  function automatic logic [3*W-1:0] pk(input int l2, input int l1, input int l0);
    return {W'(l2), W'(l1), W'(l0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mem();
    for (int k = 0; k < N; k++) begin
      m_mask[k] = 3'b000;
      m_act[k]  = 1'b0;
      m_lits[k] = '0;
    end
  endtask

  task automatic set_cl(input int k, input logic act, input logic [2:0] mask, input logic [3*W-1:0] lits);
    m_act[k]  = act;
    m_mask[k] = mask;
    m_lits[k] = lits;
  endtask

  // Start a pass and count negedges until done; optional extra start pulse at cycle restart_at.
  task automatic run_pass(input string tag, input int restart_at, output int cyc,
                          output int maxa, output int firsta);
    cyc = 0; maxa = -1; firsta = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (rd_en) begin
        if (firsta < 0) firsta = int'(rd_addr);
        if (int'(rd_addr) > maxa) maxa = int'(rd_addr);
      end
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "/done_seen"}, 32'(done), 32'd1);
    chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic chk_res(input string t, input logic uf, input int ul, input logic ub, input int ui,
                         input logic cf, input int ci, input int ac, input logic e_sat);
    chk({t, "/unit_found"}, 32'(unit_found), 32'(uf));
    chk({t, "/unit_literal"}, 32'(unit_literal), 32'(ul));
    chk({t, "/unit_bool"}, 32'(unit_bool_val), 32'(ub));
    chk({t, "/unit_idx"}, 32'(unit_clause_idx), 32'(ui));
    chk({t, "/conflict"}, 32'(conflict), 32'(cf));
    chk({t, "/conflict_idx"}, 32'(conflict_idx), 32'(ci));
    chk({t, "/active_count"}, 32'(active_count), 32'(ac));
    chk({t, "/all_sat"}, 32'(e_sat), 32'(all_sat) ^ 32'd0);
  endtask

  int cyc, maxa, firsta, waited;
  logic seen_late;

  initial begin
    rst = 1'b1; start = 1'b0;
    clr_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/rd_en", 32'(rd_en), 32'd0);
    chk_res("rst", 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;

    // All clauses satisfied
    clr_mem();
    run_pass("allsat", 0, cyc, maxa, firsta);
    chk("allsat/cycles", 32'(cyc), 32'd9);
    chk("allsat/max_addr", 32'(maxa), 32'd3);
    chk_res("allsat", 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b1);

    // Single unit on -3 in clause 2
    clr_mem();
    set_cl(2, 1'b1, 3'b010, pk(5, -3, 7));
    run_pass("unit", 0, cyc, maxa, firsta);
    chk("unit/cycles", 32'(cyc), 32'd9);
    chk_res("unit", 1'b1, 3, 1'b0, 2, 1'b0, 0, 1, 1'b0);

    // Empty active clause 1 stops the scan
    clr_mem();
    set_cl(1, 1'b1, 3'b000, pk(1, 2, 3));
    set_cl(2, 1'b1, 3'b001, pk(0, 0, 5));
    run_pass("empty", 0, cyc, maxa, firsta);
    chk("empty/cycles", 32'(cyc), 32'd5);
    chk("empty/max_addr", 32'(maxa), 32'd1);
    chk_res("empty", 1'b0, 0, 1'b0, 0, 1'b1, 1, 1, 1'b0);

    // Contradictory units +4 / -4
    clr_mem();
    set_cl(0, 1'b1, 3'b001, pk(0, 0, 4));
    set_cl(3, 1'b1, 3'b010, pk(0, -4, 0));
    run_pass("contra", 0, cyc, maxa, firsta);
    chk("contra/cycles", 32'(cyc), 32'd9);
    chk_res("contra", 1'b1, 4, 1'b1, 0, 1'b1, 3, 2, 1'b0);

    // Consistent repeat of +4 plus a different-variable unit: first unit kept
    clr_mem();
    set_cl(0, 1'b1, 3'b001, pk(0, 0, 4));
    set_cl(2, 1'b1, 3'b100, pk(7, 0, 0));
    set_cl(3, 1'b1, 3'b010, pk(0, 4, 0));
    run_pass("agree", 0, cyc, maxa, firsta);
    chk_res("agree", 1'b1, 4, 1'b1, 0, 1'b0, 0, 3, 1'b0);

    // Zero slots and -256 count as empty
    clr_mem();
    set_cl(0, 1'b1, 3'b011, pk(0, 0, 6));
    set_cl(1, 1'b1, 3'b010, pk(0, -256, 0));
    run_pass("zslot", 0, cyc, maxa, firsta);
    chk("zslot/cycles", 32'(cyc), 32'd5);
    chk_res("zslot", 1'b1, 6, 1'b1, 0, 1'b1, 1, 2, 1'b0);

    clr_mem();
    set_cl(0, 1'b1, 3'b001, pk(1, 2, 0));
    run_pass("z0", 0, cyc, maxa, firsta);
    chk("z0/cycles", 32'(cyc), 32'd3);
    chk_res("z0", 1'b0, 0, 1'b0, 0, 1'b1, 0, 1, 1'b0);

    // Reset while waiting on clause 2 with a slow store; the late response must be ignored
    clr_mem();
    for (int k = 0; k < N; k++) set_cl(k, 1'b1, 3'b111, pk(1, 2, 3));
    lat = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!(rd_en && rd_addr == 2'd2) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("mrst/reached_clause2", 32'(rd_en && rd_addr == 2'd2), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst/busy", 32'(busy), 32'd0);
    chk("mrst/rd_en", 32'(rd_en), 32'd0);
    chk("mrst/rd_addr", 32'(rd_addr), 32'd0);
    chk("mrst/done", 32'(done), 32'd0);
    chk_res("mrst", 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    seen_late = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rd_valid) seen_late = 1'b1;
    end
    chk("mrst/late_valid_arrived", 32'(seen_late), 32'd1);
    chk("mrst/idle_busy", 32'(busy), 32'd0);
    chk("mrst/idle_count", 32'(active_count), 32'd0);
    chk("mrst/idle_rd_en", 32'(rd_en), 32'd0);
    @(posedge clk); #1;
    lat = 1;
    run_pass("rerun", 3, cyc, maxa, firsta);
    chk("rerun/first_addr", 32'(firsta), 32'd0);
    chk("rerun/cycles", 32'(cyc), 32'd9);
    chk_res("rerun", 1'b0, 0, 1'b0, 0, 1'b0, 0, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/unit_clause_scan_ctrl.md
Name: unit_clause_scan_ctrl

Overview:
- Sequential stage directly downstream of the per-clause unit/pure-literal update logic.
- Walks the clause store one clause per read and classifies each clause as satisfied, unit or conflicting.
- Reports the first unit literal, or a conflict, to the DPLL decision/propagation controller. Also counts the active clauses.

Parameters:
WIDTH, 9, signed literal width; two's-complement, negative value = negated variable, 0 = empty slot
NUM_CLAUSES, 256, number of clauses scanned per pass
IDX_W, 8, clause index width; must satisfy 2^IDX_W >= NUM_CLAUSES

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a scan pass; sampled only in IDLE
rd_en  output  1  read request to clause store; single-cycle pulse
rd_addr  output  IDX_W  clause index being read
rd_valid  input  1  read data valid; any latency >= 1 cycle
clause_in  input  3  per-position unresolved mask from the update stage; bit=1 means the literal is still open
clause_active_in  input  1  clause not yet satisfied
CNF_CLAUSE_packed  input  3*WIDTH  three literals; slot i is at bits [(i+1)*WIDTH-1 -: WIDTH]
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at end of pass
unit_found  output  1  at least one unit clause found
unit_literal  output  WIDTH-1  variable index of the first unit literal
unit_bool_val  output  1  value that satisfies it: 1 for a positive literal, 0 for a negative one
unit_clause_idx  output  IDX_W  index of the first unit clause
conflict  output  1  empty active clause found, or contradictory units found
conflict_idx  output  IDX_W  clause index where the conflict was detected
active_count  output  IDX_W+1  number of active clauses evaluated
all_sat  output  1  pass finished with active_count==0 and no conflict

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FSM goes to IDLE; every output is 0. This applies mid-pass too; any in-flight rd_valid is then ignored.
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE: on start=1:
  - clear all result outputs;
  - set idx=0 and busy=1;
  - go to ISSUE.
- ISSUE: drive rd_en=1 and rd_addr=idx for exactly one cycle, then go to WAIT.
- WAIT: hold until rd_valid=1. Evaluate the clause in that same cycle using the rules below. Then:
  - conflict detected -> FIN;
  - otherwise, idx==NUM_CLAUSES-1 -> FIN;
  - otherwise idx++ -> ISSUE.
- FIN: done=1 for one cycle, busy=0, all_sat computed. Go to IDLE. Results hold until the next accepted start.
- start while busy: ignored. rd_valid outside WAIT: ignored.
- Latency with a 1-cycle store: 2*NUM_CLAUSES+1 cycles from start to done with no conflict.
- Position qualification: a slot is open only if its clause_in bit is 1 and its literal magnitude is nonzero. The magnitude is the low WIDTH-1 bits of the absolute value, so 0 and -2^(WIDTH-1) count as empty.
- Per-clause classification:
  - clause_active_in=0: satisfied; skip; no count.
  - Active clause: active_count++.
  - Active, open count 0: conflict=1, conflict_idx=idx.
  - Active, open count 1: unit clause.
    - Positive literal: unit_literal = literal[WIDTH-2:0], bool=1.
    - Negative literal: unit_literal = (-literal)[WIDTH-2:0], bool=0.
  - Active, open count 2 or 3: no action.
- Unit handling:
  - If unit_found=0, latch the literal, bool and idx, and set unit_found=1.
  - If unit_found=1 and the new unit has the same variable with opposite bool: conflict=1, conflict_idx=idx. Same variable with the same bool: no effect. Different variable: no effect, the first unit is kept.
- Priority: an empty-clause conflict in the same clause overrides unit handling. Once conflict=1, no further clauses are read.
- active_count: never exceeds NUM_CLAUSES, so no saturation is needed.

Test Plan:
- NUM_CLAUSES=4; all clauses clause_active_in=0; start -> done after 9 cycles; active_count=0, all_sat=1, unit_found=0, conflict=0.
- Clause 2 active, literals {5,-3,7}, mask 3'b010 -> unit_literal=3, unit_bool_val=0, unit_clause_idx=2, unit_found=1.
- Clause 1 active, mask 3'b000 -> conflict=1, conflict_idx=1, rd_addr never reaches 2, done one cycle after evaluation.
- Clause 0 unit on +4, clause 3 unit on -4 -> unit_literal=4, bool=1, conflict=1, conflict_idx=3. Repeat with clause 3 on +4 -> no conflict.
- Active clause, mask 3'b011, literals {0,0,6} -> treated as unit on 6/bool=1. Mask 3'b001 with slot0 literal=0 -> conflict.
- rst asserted while in WAIT for clause 2, with rd_valid arriving afterwards -> all outputs 0, FSM IDLE, late rd_valid ignored. A subsequent start re-reads from rd_addr=0; start pulses while busy are ignored.
